rcv_bit_ctrl: RTL and testbench
===============================

RCV_BIT_CTRL -- requirements
Module: rcv_bit_ctrl

Block role: upstream control stage of the UART receive path. Synchronizes the serial line, detects and validates the start bit, times bit centres, and pulses shift_enable to the 8-bit serial-to-parallel shift register on d_sync. Checks the stop bit and flags the frame to the receive buffer.

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (1..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port n_rst, input, 1, meaning asynchronous reset, active-high (asserted = 1).
REQ-005 SHALL have port serial_in, input, 1, meaning the raw asynchronous receive line (idle high).
REQ-006 SHALL have port d_sync, output, 1, meaning the synchronized serial line that feeds the shift register's serial input.
REQ-007 SHALL have port shift_enable, output, 1, meaning a one-cycle pulse at each data-bit centre.
REQ-008 SHALL have port load_buffer, output, 1, meaning a one-cycle pulse when a frame ends with a valid stop bit.
REQ-009 SHALL have port framing_error, output, 1, meaning a level set by a bad stop bit.
REQ-010 SHALL have port rx_busy, output, 1, meaning high whenever the state machine is not in IDLE.

Function
REQ-011 SHALL pass serial_in through a two-flop synchronizer; d_sync SHALL be the second flop, so latency is 2 cycles.
REQ-012 SHALL detect a start edge when the previous d_sync is 1 and the current d_sync is 0, only while in IDLE.
REQ-013 SHALL implement the states IDLE, START_CHK, DATA, STOP and DONE, all registered.
REQ-014 SHALL, in START_CHK, wait CLKS_PER_BIT/2 cycles from the start edge and then sample d_sync.
- If the sample is 1 (false start), SHALL return to IDLE with no pulses.
- If the sample is 0, SHALL enter DATA and clear the bit and cycle counters.
REQ-015 SHALL, in DATA, count CLKS_PER_BIT cycles per bit.
- On the terminal count, SHALL assert shift_enable for exactly one cycle and increment the bit counter.
REQ-016 SHALL move from DATA to STOP on the same edge as the DATA_BITS-th shift_enable pulse.
REQ-017 SHALL, in STOP, sample d_sync after CLKS_PER_BIT cycles and then enter DONE.
- Sample = 1: SHALL set load_buffer high for one cycle and clear framing_error.
- Sample = 0: SHALL set framing_error and leave load_buffer low.
REQ-018 SHALL spend exactly one cycle in DONE, then return to IDLE.
REQ-019 SHALL hold framing_error until the next validated start bit (the START_CHK to DATA transition) or reset.
REQ-020 SHALL NOT assert shift_enable and load_buffer in the same cycle.
REQ-021 SHALL NOT assert shift_enable outside the DATA state.
REQ-022 SHALL ignore line edges while not in IDLE; a start bit that arrives during DONE is missed only if its falling edge occurs in that cycle.
REQ-023 SHALL size the cycle counter to $clog2(CLKS_PER_BIT) bits and the bit counter to $clog2(DATA_BITS+1) bits, with no wrap inside a frame.

Reset
REQ-024 SHALL, while n_rst = 1, force asynchronously:
- state = IDLE;
- both synchronizer flops = 1 (so d_sync = 1);
- counters = 0;
- shift_enable = 0, load_buffer = 0, framing_error = 0, rx_busy = 0.
REQ-025 SHALL, on reset mid-frame, abandon the frame, produce no further pulses, and after release require a fresh 1-to-0 edge to start a frame.

Verification
REQ-026 Valid frame 0xA5, LSB first, stop = 1, CLKS_PER_BIT = 10 -> exactly 8 shift_enable pulses spaced 10 cycles apart; load_buffer pulses once; the downstream register holds 0xA5; framing_error = 0.
REQ-027 Glitch: serial_in low for 3 cycles, then high -> START_CHK aborts; zero shift_enable pulses; rx_busy low again within 8 cycles.
REQ-028 Frame 0x3C with stop bit = 0 -> 8 shift_enable pulses, no load_buffer, framing_error = 1. The next valid frame 0x0F clears framing_error at its start bit and pulses load_buffer.
REQ-029 n_rst asserted after the 4th shift_enable pulse -> all outputs 0 immediately (asynchronously) and d_sync = 1. After release with the line held high, no pulses occur for 50 cycles.
REQ-030 Back-to-back frames 0x01 and 0xFE with no idle gap -> two load_buffer pulses, 16 shift_enable pulses in total, no framing_error.
REQ-031 Parameter sweep CLKS_PER_BIT = 4 and DATA_BITS = 5, frame 0x15 -> 5 pulses spaced 4 cycles apart, and the first pulse occurs 6 cycles after the synchronized start edge.

Source files
------------

// File: rtl/rcv_bit_ctrl_if.sv
// Serial receive control bus: the raw line going in, plus the synchronized
// line, the shift/load strobes and the status flags coming back out.
interface rcv_bit_ctrl_if;
  logic serial_in;
  logic d_sync;
  logic shift_enable;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  // Driver side: owns the serial line and observes the controller.
  modport master (
    output serial_in,
    input  d_sync,
    input  shift_enable,
    input  load_buffer,
    input  framing_error,
    input  rx_busy
  );

  // Controller side: consumes the serial line and produces the strobes/flags.
  modport slave (
    input  serial_in,
    output d_sync,
    output shift_enable,
    output load_buffer,
    output framing_error,
    output rx_busy
  );
endinterface

// File: rtl/rcv_bit_ctrl.sv
// UART receive bit controller: synchronizes the serial line, validates the
// start bit at its centre, strobes the downstream shift register at every
// data-bit centre and checks the stop bit before flagging the frame.
module rcv_bit_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input logic           clk,
  input logic           n_rst,
  rcv_bit_ctrl_if.slave bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  // The half-bit wait ends on HALF_LAST. The shift strobe is registered, so it
  // is launched one count early (SHIFT_AT) to land exactly on the bit centre.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SHIFT_AT  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             sync_meta;
  logic             sync_out;
  logic             prev_sync;
  logic             shift_enable;
  logic             load_buffer;
  logic             framing_error;
  logic             rx_busy;

  assign bus.d_sync        = sync_out;
  assign bus.shift_enable  = shift_enable;
  assign bus.load_buffer   = load_buffer;
  assign bus.framing_error = framing_error;
  assign bus.rx_busy       = rx_busy;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; all
  // preset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
      prev_sync <= 1'b1;
    end else begin
      sync_meta <= bus.serial_in;
      sync_out  <= sync_meta;
      prev_sync <= sync_out;
    end
  end

  // Frame state machine with registered strobes and status flags.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift_enable  <= 1'b0;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      shift_enable <= 1'b0;
      load_buffer  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (prev_sync && !sync_out) begin
            state   <= START_CHK;
            rx_busy <= 1'b1;
          end
        end
        START_CHK: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            if (sync_out) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state         <= DATA;
              framing_error <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
          if (cnt == SHIFT_AT) begin
            shift_enable <= 1'b1;
            bit_cnt      <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              cnt   <= '0;
            end
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            cnt   <= '0;
            if (sync_out) begin
              load_buffer   <= 1'b1;
              framing_error <= 1'b0;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcv_bit_ctrl.sv
// Bench for rcv_bit_ctrl: a default instance (10 clocks/bit, 8 data bits)
// driven from a table of frames plus hand-written corner sequences, and a
// small instance (4 clocks/bit, 5 data bits) for the parameter sweep.
module tb_rcv_bit_ctrl;

  logic clk;
  logic rst1;
  logic rst2;

  rcv_bit_ctrl_if bus1 ();
  rcv_bit_ctrl_if bus2 ();

  rcv_bit_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut1 (
    .clk   (clk),
    .n_rst (rst1),
    .bus   (bus1.slave)
  );

  rcv_bit_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(5)) dut2 (
    .clk   (clk),
    .n_rst (rst2),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_se;
    int         exp_lb;
    logic       exp_ferr;
    logic       exp_mid_ferr;
  } vec_t;

  vec_t vecs [5];

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  int         se1_cnt = 0;
  int         lb1_cnt = 0;
  int         se2_cnt = 0;
  int         lb2_cnt = 0;
  int         overlap = 0;
  int         se1_ring [16];
  int         se2_ring [16];
  logic [7:0] sr1 = '0;
  logic [4:0] sr2 = '0;
  logic [7:0] loaded1 [8];
  logic [4:0] loaded2 = '0;
  logic       d2_prev = 1'b1;
  int         edge2 = 0;
  logic       mid_ferr;
  logic       mid_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream model and pulse bookkeeping, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus1.shift_enable) begin
      sr1 <= {bus1.d_sync, sr1[7:1]};
      se1_ring[se1_cnt % 16] <= cyc;
      se1_cnt <= se1_cnt + 1;
    end
    if (bus1.load_buffer) begin
      loaded1[lb1_cnt % 8] <= sr1;
      lb1_cnt <= lb1_cnt + 1;
    end
    if (bus2.shift_enable) begin
      sr2 <= {bus2.d_sync, sr2[4:1]};
      se2_ring[se2_cnt % 16] <= cyc;
      se2_cnt <= se2_cnt + 1;
    end
    if (bus2.load_buffer) begin
      loaded2 <= sr2;
      lb2_cnt <= lb2_cnt + 1;
    end
    if ((bus1.shift_enable && bus1.load_buffer) || (bus2.shift_enable && bus2.load_buffer))
      overlap <= overlap + 1;
    if (d2_prev && !bus2.d_sync && !bus2.rx_busy)
      edge2 <= cyc;
    d2_prev <= bus2.d_sync;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Sends one 10-clock/bit frame to the default instance, then idles high.
  task automatic applyStimulus(input logic [7:0] data, input logic stop);
    logic bits [10];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9] = stop;
    for (int b = 0; b < 10; b++) begin
      bus1.serial_in = bits[b];
      repeat (10) tick();
      if (b == 3) begin
        mid_ferr = bus1.framing_error;
        mid_busy = bus1.rx_busy;
      end
    end
    bus1.serial_in = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    int   snap_se;
    int   snap_lb;
    int   idle_at;
    int   hit;
    int   spacing_ok;
    logic saw;
    logic bits20 [20];
    logic [7:0] b2b_a;
    logic [7:0] b2b_b;
    logic [4:0] sweep_data;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_se: 8, exp_lb: 1, exp_ferr: 1'b0, exp_mid_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_se: 8, exp_lb: 0, exp_ferr: 1'b1, exp_mid_ferr: 1'b0};
    vecs[2] = '{data: 8'h0F, stop: 1'b1, exp_se: 8, exp_lb: 1, exp_ferr: 1'b0, exp_mid_ferr: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_se: 8, exp_lb: 1, exp_ferr: 1'b0, exp_mid_ferr: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b0, exp_se: 8, exp_lb: 0, exp_ferr: 1'b1, exp_mid_ferr: 1'b0};

    // Reset state, with the line held low to show d_sync is forced high.
    rst1 = 1'b1;
    rst2 = 1'b1;
    bus1.serial_in = 1'b0;
    bus2.serial_in = 1'b0;
    repeat (3) tick();
    checkOutput("rst_d_sync", int'(bus1.d_sync), 1);
    checkOutput("rst_shift_enable", int'(bus1.shift_enable), 0);
    checkOutput("rst_load_buffer", int'(bus1.load_buffer), 0);
    checkOutput("rst_framing_error", int'(bus1.framing_error), 0);
    checkOutput("rst_rx_busy", int'(bus1.rx_busy), 0);
    checkOutput("rst2_d_sync", int'(bus2.d_sync), 1);
    checkOutput("rst2_rx_busy", int'(bus2.rx_busy), 0);
    bus1.serial_in = 1'b1;
    bus2.serial_in = 1'b1;
    repeat (2) tick();
    rst1 = 1'b0;
    rst2 = 1'b0;
    repeat (5) tick();

    // Table of whole frames on the default instance.
    for (int v = 0; v < 5; v++) begin
      snap_se = se1_cnt;
      snap_lb = lb1_cnt;
      applyStimulus(vecs[v].data, vecs[v].stop);
      checkOutput($sformatf("vec%0d_shift_count", v), se1_cnt - snap_se, vecs[v].exp_se);
      checkOutput($sformatf("vec%0d_load_count", v), lb1_cnt - snap_lb, vecs[v].exp_lb);
      checkOutput($sformatf("vec%0d_framing_error", v), int'(bus1.framing_error), int'(vecs[v].exp_ferr));
      checkOutput($sformatf("vec%0d_mid_framing_error", v), int'(mid_ferr), int'(vecs[v].exp_mid_ferr));
      checkOutput($sformatf("vec%0d_mid_busy", v), int'(mid_busy), 1);
      checkOutput($sformatf("vec%0d_shifted_data", v), int'(sr1), int'(vecs[v].data));
      checkOutput($sformatf("vec%0d_busy_after", v), int'(bus1.rx_busy), 0);
      spacing_ok = 1;
      for (int k = 1; k < 8; k++)
        if (se1_ring[(snap_se + k) % 16] - se1_ring[(snap_se + k - 1) % 16] != 10) spacing_ok = 0;
      checkOutput($sformatf("vec%0d_pulse_spacing", v), spacing_ok, 1);
    end

    // Short glitch: false start must abort quietly and keep the old error flag.
    snap_se = se1_cnt;
    snap_lb = lb1_cnt;
    saw = 1'b0;
    idle_at = -1;
    bus1.serial_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      saw = saw | bus1.rx_busy;
    end
    bus1.serial_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (saw && !bus1.rx_busy && idle_at < 0) idle_at = k;
      saw = saw | bus1.rx_busy;
    end
    repeat (20) tick();
    checkOutput("glitch_saw_busy", int'(saw), 1);
    checkOutput("glitch_idle_within_8", int'(idle_at >= 1 && idle_at <= 8), 1);
    checkOutput("glitch_shift_count", se1_cnt - snap_se, 0);
    checkOutput("glitch_load_count", lb1_cnt - snap_lb, 0);
    checkOutput("glitch_keeps_framing_error", int'(bus1.framing_error), 1);

    // Back-to-back frames with no idle gap between stop and next start.
    b2b_a = 8'h01;
    b2b_b = 8'hFE;
    bits20[0] = 1'b0;
    bits20[10] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits20[i+1]  = b2b_a[i];
      bits20[i+11] = b2b_b[i];
    end
    bits20[9]  = 1'b1;
    bits20[19] = 1'b1;
    snap_se = se1_cnt;
    snap_lb = lb1_cnt;
    for (int b = 0; b < 20; b++) begin
      bus1.serial_in = bits20[b];
      repeat (10) tick();
    end
    bus1.serial_in = 1'b1;
    repeat (20) tick();
    checkOutput("b2b_shift_count", se1_cnt - snap_se, 16);
    checkOutput("b2b_load_count", lb1_cnt - snap_lb, 2);
    checkOutput("b2b_first_byte", int'(loaded1[snap_lb % 8]), 8'h01);
    checkOutput("b2b_second_byte", int'(loaded1[(snap_lb + 1) % 8]), 8'hFE);
    checkOutput("b2b_framing_error", int'(bus1.framing_error), 0);

    // Reset right after the 4th shift pulse of frame 0xA5.
    bits20[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits20[i+1] = b2b_a[i] ^ b2b_a[i] ^ ((8'hA5 >> i) & 1'b1);
    bits20[9] = 1'b1;
    snap_se = se1_cnt;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 10 == 0) bus1.serial_in = bits20[c / 10];
      tick();
      if (se1_cnt - snap_se == 4) begin
        hit = 1;
        break;
      end
    end
    checkOutput("midrst_reached_4th_pulse", hit, 1);
    checkOutput("midrst_pulse_high_before", int'(bus1.shift_enable), 1);
    bus1.serial_in = 1'b0;
    rst1 = 1'b1;
    #1;
    checkOutput("midrst_shift_enable", int'(bus1.shift_enable), 0);
    checkOutput("midrst_load_buffer", int'(bus1.load_buffer), 0);
    checkOutput("midrst_framing_error", int'(bus1.framing_error), 0);
    checkOutput("midrst_rx_busy", int'(bus1.rx_busy), 0);
    checkOutput("midrst_d_sync", int'(bus1.d_sync), 1);
    bus1.serial_in = 1'b1;
    repeat (3) tick();
    rst1 = 1'b0;
    snap_se = se1_cnt;
    snap_lb = lb1_cnt;
    repeat (50) tick();
    checkOutput("postrst_shift_count", se1_cnt - snap_se, 0);
    checkOutput("postrst_load_count", lb1_cnt - snap_lb, 0);
    checkOutput("postrst_rx_busy", int'(bus1.rx_busy), 0);

    // Parameter sweep instance: 4 clocks/bit, 5 data bits, frame 0x15.
    sweep_data = 5'h15;
    snap_se = se2_cnt;
    snap_lb = lb2_cnt;
    bus2.serial_in = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      bus2.serial_in = sweep_data[i];
      repeat (4) tick();
    end
    bus2.serial_in = 1'b1;
    repeat (20) tick();
    checkOutput("sweep_shift_count", se2_cnt - snap_se, 5);
    checkOutput("sweep_load_count", lb2_cnt - snap_lb, 1);
    checkOutput("sweep_first_pulse_delay", se2_ring[snap_se % 16] - edge2, 6);
    spacing_ok = 1;
    for (int k = 1; k < 5; k++)
      if (se2_ring[(snap_se + k) % 16] - se2_ring[(snap_se + k - 1) % 16] != 4) spacing_ok = 0;
    checkOutput("sweep_pulse_spacing", spacing_ok, 1);
    checkOutput("sweep_loaded_data", int'(loaded2), 5'h15);
    checkOutput("sweep_framing_error", int'(bus2.framing_error), 0);

    checkOutput("no_shift_load_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
